// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU scheduler: FSM states, ALU select codes, flag bit positions
// and a saturating increment used by the optional statistics counters.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NOT = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_LT  = 3'b110,
        OP_EQ  = 3'b111
    } op_t;

    // Bit positions inside the 3-bit led/flags vector {overflow, carry, zero}
    typedef enum logic [1:0] {
        FLG_ZERO  = 2'd0,
        FLG_CARRY = 2'd1,
        FLG_OVF   = 2'd2
    } flag_idx_t;

    localparam logic [7:0] STAT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == STAT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request strictly after
// the pointer (wrapping) wins; emits a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Offsets 1..N_REQ visit every requester once, the pointer holder last
        for (int k = 1; k <= N_REQ; k++) begin
            int cand;
            cand = (int'(ptr) + k) % N_REQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one combinational 4-bit ALU between N_REQ requesters.
// Optional statistics ports stat_ops/stat_ovf are built when ALU_SCHED_STATS_EN is defined.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [4*N_REQ-1:0] req_x,
    input  logic [4*N_REQ-1:0] req_y,
    input  logic [3*N_REQ-1:0] req_op,
    output logic [3:0]         alu_x,
    output logic [3:0]         alu_y,
    output logic [2:0]         alu_sel,
    input  logic [3:0]         alu_out,
    input  logic [2:0]         alu_led,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [3:0]         rsp_out,
    output logic [2:0]         rsp_flags
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [7:0]         stat_ops,
    output logic [7:0]         stat_ovf
`endif
);

    state_t            state_reg;
    logic [ID_W-1:0]   ptr_reg;

    logic [3:0]        x_arr  [N_REQ];
    logic [3:0]        y_arr  [N_REQ];
    logic [2:0]        op_arr [N_REQ];

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_any;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign x_arr[gi]  = req_x[4*gi +: 4];
            assign y_arr[gi]  = req_y[4*gi +: 4];
            assign op_arr[gi] = req_op[3*gi +: 3];
        end
    endgenerate

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Ready is only offered while idle, so a grant is never taken mid-operation
    assign req_ready = (state_reg == S_IDLE) ? grant : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            ptr_reg   <= ID_W'(N_REQ - 1);
            alu_x     <= '0;
            alu_y     <= '0;
            alu_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_out   <= '0;
            rsp_flags <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (grant_any) begin
                        alu_x     <= x_arr[grant_idx];
                        alu_y     <= y_arr[grant_idx];
                        alu_sel   <= op_arr[grant_idx];
                        rsp_id    <= grant_idx;
                        ptr_reg   <= grant_idx;
                        state_reg <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // ALU inputs have been stable for a full cycle; capture its result
                    rsp_out   <= alu_out;
                    rsp_flags <= alu_led;
                    rsp_valid <= 1'b1;
                    state_reg <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops <= '0;
            stat_ovf <= '0;
        end else if (state_reg == S_RESP && rsp_ready) begin
            stat_ops <= sat_inc(stat_ops);
            if (rsp_flags[FLG_OVF]) begin
                stat_ovf <= sat_inc(stat_ovf);
            end
        end
    end
`endif

endmodule
